// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: control bit positions, access sizes,
// multiply ALU codes and the access FSM states.
package mem_stage_pkg;

    localparam int CTRL_W = 9;

    // Bit positions use big-endian numbering (bit 0 = MSB), mapped onto [8:0].
    localparam int CTRL_MEM_RD = CTRL_W - 1 - 2;
    localparam int CTRL_MEM_WR = CTRL_W - 1 - 3;
    localparam int CTRL_REG_WR = CTRL_W - 1 - 5;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_WORD2 = 2'b11;

    localparam logic [5:0] ALU_MUL  = 6'h0e;
    localparam logic [5:0] ALU_MULU = 6'h16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Big-endian lane steering: store replication/byte enables, load
// extract and extend, and the alignment check.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = store_data;
        unique case (size)
            SZ_BYTE: begin
                be    = 4'b1000 >> offset;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                misaligned = offset[0];
                be         = offset[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{store_data[15:0]}};
            end
            default: misaligned = |offset;
        endcase
    end

    // Byte 0 is the most significant byte of the word.
    always_comb begin
        lane8 = load_data[31:24];
        unique case (offset)
            2'd0: lane8 = load_data[31:24];
            2'd1: lane8 = load_data[23:16];
            2'd2: lane8 = load_data[15:8];
            2'd3: lane8 = load_data[7:0];
        endcase
        lane16 = offset[1] ? load_data[15:0] : load_data[31:16];
    end

    always_comb begin
        rdata = load_data;
        unique case (size)
            SZ_BYTE: rdata = {{24{~zext & lane8[7]}}, lane8};
            SZ_HALF: rdata = {{16{~zext & lane16[15]}}, lane16};
            default: rdata = load_data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack access, stall generation,
// forwarding to EX and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter bit ZERO_WAIT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        ctrl,
    input  logic [5:0]        alu_ctrl,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       mult_out,
    input  logic [31:0]       write_data,
    input  logic [2:0]        dmem_info,
    input  logic [4:0]        write_reg,
    input  logic              fp_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic              misalign,
    output logic              reg_write_mem,
    output logic [4:0]        write_reg_mem,
    output logic [31:0]       write_val_mem,
    output logic              reg_write_wb,
    output logic [4:0]        write_reg_wb,
    output logic [31:0]       write_val_wb,
    output logic              fp_write_wb
);

    mem_state_t  state;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_op;
    logic        unaligned;
    logic        bad;
    logic        done;
    logic [31:0] load_val;
    logic [31:0] result;
    logic        ctrl_unused;

    assign mem_rd      = ctrl[CTRL_MEM_RD];
    assign mem_wr      = ctrl[CTRL_MEM_WR];
    assign mem_op      = mem_rd | mem_wr;
    assign ctrl_unused = ^ctrl;

    mem_align u_align (
        .size       (dmem_info[2:1]),
        .zext       (dmem_info[0]),
        .offset     (alu_out[1:0]),
        .store_data (write_data),
        .load_data  (dmem_rdata),
        .misaligned (unaligned),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .rdata      (load_val)
    );

    // The EX inputs are frozen while waiting, so the request stays stable.
    always_comb begin
        bad       = mem_op & unaligned & (state == ST_IDLE);
        dmem_req  = ~reset & ((state == ST_WAIT) | (mem_op & ~unaligned));
        dmem_we   = dmem_req & mem_wr;
        dmem_addr = {alu_out[ADDR_W-1:2], 2'b00};
        done      = dmem_req & dmem_ack & ((state == ST_WAIT) | ZERO_WAIT);
        mem_stall = dmem_req & ~done;
        misalign  = ~reset & bad;
    end

    always_comb begin
        result = alu_out;
        if (alu_ctrl == ALU_MUL || alu_ctrl == ALU_MULU)
            result = mult_out;
        reg_write_mem = ctrl[CTRL_REG_WR] & ~bad & (~mem_rd | done);
        write_reg_mem = write_reg;
        write_val_mem = mem_rd ? load_val : result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            reg_write_wb <= 1'b0;
            write_reg_wb <= '0;
            write_val_wb <= '0;
            fp_write_wb  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (mem_stall) state <= ST_WAIT;
                ST_WAIT: if (done)      state <= ST_IDLE;
            endcase
            if (mem_stall | bad) begin
                reg_write_wb <= 1'b0;
            end else begin
                reg_write_wb <= reg_write_mem;
                write_reg_wb <= write_reg;
                write_val_wb <= write_val_mem;
                fp_write_wb  <= fp_write;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, alignment faults,
// multiply forwarding and reset during an outstanding access.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  ctrl;
    logic [5:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic [31:0] mult_out;
    logic [31:0] write_data;
    logic [2:0]  dmem_info;
    logic [4:0]  write_reg;
    logic        fp_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        misalign;
    logic        reg_write_mem;
    logic [4:0]  write_reg_mem;
    logic [31:0] write_val_mem;
    logic        reg_write_wb;
    logic [4:0]  write_reg_wb;
    logic [31:0] write_val_wb;
    logic        fp_write_wb;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] C_RD;
    logic [8:0] C_WR;
    logic [8:0] C_RW;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl          (ctrl),
        .alu_ctrl      (alu_ctrl),
        .alu_out       (alu_out),
        .mult_out      (mult_out),
        .write_data    (write_data),
        .dmem_info     (dmem_info),
        .write_reg     (write_reg),
        .fp_write      (fp_write),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .mem_stall     (mem_stall),
        .misalign      (misalign),
        .reg_write_mem (reg_write_mem),
        .write_reg_mem (write_reg_mem),
        .write_val_mem (write_val_mem),
        .reg_write_wb  (reg_write_wb),
        .write_reg_wb  (write_reg_wb),
        .write_val_wb  (write_val_wb),
        .fp_write_wb   (fp_write_wb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        ctrl       = '0;
        alu_ctrl   = '0;
        alu_out    = '0;
        mult_out   = '0;
        write_data = '0;
        dmem_info  = '0;
        write_reg  = '0;
        fp_write   = 1'b0;
        dmem_rdata = '0;
        dmem_ack   = 1'b0;
    endtask

    initial begin
        C_RD = '0;
        C_RD[CTRL_MEM_RD] = 1'b1;
        C_WR = '0;
        C_WR[CTRL_MEM_WR] = 1'b1;
        C_RW = '0;
        C_RW[CTRL_REG_WR] = 1'b1;
        nop();
        reset = 1'b1;
        tick();
        check("rst_rw_wb", reg_write_wb, 0);
        check("rst_val_wb", write_val_wb, 0);
        check("rst_req", dmem_req, 0);
        check("rst_stall", mem_stall, 0);
        reset = 1'b0;

        // word load, zero-wait
        ctrl = C_RD | C_RW; dmem_info = 3'b100; alu_out = 32'h100;
        write_reg = 5'd7; dmem_rdata = 32'hDEADBEEF; dmem_ack = 1'b1;
        #1;
        check("wl_req", dmem_req, 1);
        check("wl_we", dmem_we, 0);
        check("wl_stall", mem_stall, 0);
        check("wl_addr", dmem_addr, 32'h100);
        check("wl_fwd_rw", reg_write_mem, 1);
        check("wl_fwd_val", write_val_mem, 32'hDEADBEEF);
        tick();
        check("wl_rw_wb", reg_write_wb, 1);
        check("wl_val_wb", write_val_wb, 32'hDEADBEEF);
        check("wl_reg_wb", write_reg_wb, 7);
        nop();

        // signed then unsigned byte load, ack after 3 stall cycles
        for (int z = 0; z < 2; z++) begin
            ctrl = C_RD | C_RW; dmem_info = (z == 0) ? 3'b000 : 3'b001;
            alu_out = 32'h103; write_reg = 5'd3; dmem_ack = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1;
                check("bl_stall", mem_stall, 1);
                check("bl_req", dmem_req, 1);
                check("bl_fwd_rw", reg_write_mem, 0);
                tick();
                check("bl_bubble", reg_write_wb, 0);
            end
            dmem_ack = 1'b1; dmem_rdata = 32'h000000F0;
            #1;
            check("bl_ack_stall", mem_stall, 0);
            check("bl_fwd_rw2", reg_write_mem, 1);
            tick();
            check("bl_rw_wb", reg_write_wb, 1);
            check("bl_val_wb", write_val_wb,
                  (z == 0) ? 32'hFFFFFFF0 : 32'h000000F0);
            nop();
        end

        // half store at offset 2
        ctrl = C_WR; dmem_info = 3'b010; alu_out = 32'h202;
        write_data = 32'h1234ABCD; dmem_ack = 1'b1;
        #1;
        check("hs_be", dmem_be, 4'b0011);
        check("hs_wdata", dmem_wdata, 32'hABCDABCD);
        check("hs_we", dmem_we, 1);
        check("hs_addr", dmem_addr, 32'h200);
        check("hs_stall", mem_stall, 0);
        tick();
        check("hs_rw_wb", reg_write_wb, 0);
        nop();

        // byte store at offset 1
        ctrl = C_WR; dmem_info = 3'b000; alu_out = 32'h301;
        write_data = 32'h000000A5; dmem_ack = 1'b1;
        #1;
        check("bs_be", dmem_be, 4'b0100);
        check("bs_wdata", dmem_wdata, 32'hA5A5A5A5);
        tick();
        nop();

        // signed half load at offset 0
        ctrl = C_RD | C_RW; dmem_info = 3'b010; alu_out = 32'h200;
        dmem_rdata = 32'h80011234; dmem_ack = 1'b1; write_reg = 5'd4;
        #1;
        check("hl_fwd_val", write_val_mem, 32'hFFFF8001);
        tick();
        nop();

        // misaligned word load
        ctrl = C_RD | C_RW; dmem_info = 3'b100; alu_out = 32'h101;
        write_reg = 5'd9; dmem_ack = 1'b1;
        #1;
        check("ma_pulse", misalign, 1);
        check("ma_req", dmem_req, 0);
        check("ma_stall", mem_stall, 0);
        check("ma_fwd_rw", reg_write_mem, 0);
        tick();
        check("ma_rw_wb", reg_write_wb, 0);
        nop();
        #1;
        check("ma_pulse_end", misalign, 0);

        // multiply result forwarding
        ctrl = C_RW; alu_ctrl = 6'h0e; mult_out = 32'h7; alu_out = 32'h55;
        write_reg = 5'd12; fp_write = 1'b1;
        #1;
        check("mul_fwd_val", write_val_mem, 32'h7);
        check("mul_fwd_rw", reg_write_mem, 1);
        tick();
        check("mul_val_wb", write_val_wb, 32'h7);
        check("mul_fp_wb", fp_write_wb, 1);
        alu_ctrl = 6'h16; mult_out = 32'h9;
        #1;
        check("mulu_fwd_val", write_val_mem, 32'h9);
        alu_ctrl = 6'h20;
        #1;
        check("alu_fwd_val", write_val_mem, 32'h55);
        tick();
        nop();

        // reset in the second wait cycle
        ctrl = C_RD | C_RW; dmem_info = 3'b100; alu_out = 32'h300;
        write_reg = 5'd9; dmem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rw_req_rst", dmem_req, 0);
        tick();
        reset = 1'b0;
        nop();
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        check("rw_req", dmem_req, 0);
        check("rw_stall", mem_stall, 0);
        tick();
        check("rw_rw_wb", reg_write_wb, 0);
        check("rw_val_wb", write_val_wb, 0);
        check("rw_reg_wb", write_reg_wb, 0);
        ctrl = C_RD | C_RW; dmem_info = 3'b100; alu_out = 32'h400;
        write_reg = 5'd2; dmem_rdata = 32'h11223344; dmem_ack = 1'b1;
        #1;
        check("rw_idle_stall", mem_stall, 0);
        tick();
        check("rw_idle_val", write_val_wb, 32'h11223344);
        nop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
